// File: rtl/apex_arb_pkg.sv
// Shared states, constants and helpers for the apex category arbiter.
// Optional macro APEX_ARB_RETRY_EN adds the RETRY state for re-granting a timed-out winner.
package apex_arb_pkg;

  localparam int         NUM_CAT   = 6;
  localparam logic [2:0] IBT_NONE  = 3'b000;
  localparam logic [2:0] IBT_BASE  = 3'd2;
  // Pointer starts on the last category so cat0 wins the first search.
  localparam logic [2:0] PTR_RESET = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
`ifdef APEX_ARB_RETRY_EN
    ST_RETRY = 2'd2,
`endif
    ST_ERR   = 2'd3
  } arb_state_t;

  function automatic logic [2:0] ibt_of(input logic [2:0] idx);
    return idx + IBT_BASE;
  endfunction

  function automatic logic [NUM_CAT-1:0] cat_onehot(input logic [2:0] idx);
    return NUM_CAT'(1) << idx;
  endfunction

endpackage

// File: rtl/apex_cat_arbiter_if.sv
// Category request/grant bundle. master = arbiter side (drives grants),
// slave = category source side (drives req/done).
interface apex_cat_arbiter_if;
  import apex_arb_pkg::*;

  logic [NUM_CAT-1:0] req;
  logic               done;
  logic [NUM_CAT-1:0] gnt;
  logic [2:0]         ibt;
  logic               busy;
  logic               verr;

  modport master (
    input  req,
    input  done,
    output gnt,
    output ibt,
    output busy,
    output verr
  );

  modport slave (
    output req,
    output done,
    input  gnt,
    input  ibt,
    input  busy,
    input  verr
  );

endinterface

// File: rtl/apex_rr_pick.sv
// Combinational 6-way round-robin picker: first set request strictly after
// the pointer, wrapping modulo NUM_CAT.
module apex_rr_pick
  import apex_arb_pkg::*;
(
  input  logic [NUM_CAT-1:0] req,
  input  logic [2:0]         pointer,
  output logic [2:0]         winner,
  output logic               valid
);

  logic [3:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_CAT; i++) begin
      cand = {1'b0, pointer} + 4'(i);
      if (cand >= 4'(NUM_CAT)) cand = cand - 4'(NUM_CAT);
      if (!valid && req[cand[2:0]]) begin
        winner = cand[2:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apex_cat_arbiter.sv
// Round-robin category arbiter with per-grant watchdog and sticky timeout error.
// APEX_ARB_RETRY_EN enables RETRY re-grants (up to RETRY_MAX timeouts) before ERR.
module apex_cat_arbiter
  import apex_arb_pkg::*;
#(
  parameter int WATCH_MAX = 100,
  parameter int RETRY_MAX = 3
) (
  input logic               clk,
  input logic               rst_n,
  input logic               iclr,
  apex_cat_arbiter_if.master bus
);

  if (WATCH_MAX < 2 || WATCH_MAX > 127) begin : g_bad_watch
    $error("WATCH_MAX must be in 2..127");
  end
  if (RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_bad_retry
    $error("RETRY_MAX must be in 1..15");
  end

  localparam logic [6:0] WATCH_LAST = 7'(WATCH_MAX - 1);

  arb_state_t         state;
  logic [NUM_CAT-1:0] gnt_q;
  logic [2:0]         ibt_q;
  logic               busy_q;
  logic               verr_q;
  logic [6:0]         watch;
  logic [2:0]         pointer;
  logic [2:0]         winner_q;
  logic [2:0]         pick_idx;
  logic               pick_valid;
  logic               timeout;

`ifdef APEX_ARB_RETRY_EN
  localparam logic [4:0] RETRY_LIM = 5'(RETRY_MAX);
  logic [3:0] star;
`endif

  apex_rr_pick u_pick (
    .req     (bus.req),
    .pointer (pointer),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  assign timeout = (watch == WATCH_LAST);

  // Single FSM block; done beats a coincident timeout so no retry is charged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      ibt_q    <= IBT_NONE;
      busy_q   <= 1'b0;
      verr_q   <= 1'b0;
      watch    <= '0;
      pointer  <= PTR_RESET;
      winner_q <= '0;
`ifdef APEX_ARB_RETRY_EN
      star     <= '0;
`endif
    end else if (iclr) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      ibt_q    <= IBT_NONE;
      busy_q   <= 1'b0;
      verr_q   <= 1'b0;
      watch    <= '0;
      pointer  <= PTR_RESET;
      winner_q <= '0;
`ifdef APEX_ARB_RETRY_EN
      star     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            winner_q <= pick_idx;
            gnt_q    <= cat_onehot(pick_idx);
            ibt_q    <= ibt_of(pick_idx);
            watch    <= '0;
`ifdef APEX_ARB_RETRY_EN
            star     <= '0;
`endif
            busy_q   <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (bus.done) begin
            gnt_q   <= '0;
            ibt_q   <= IBT_NONE;
            pointer <= winner_q;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (timeout) begin
            gnt_q <= '0;
            ibt_q <= IBT_NONE;
`ifdef APEX_ARB_RETRY_EN
            star  <= star + 4'd1;
            if (({1'b0, star} + 5'd1) < RETRY_LIM) begin
              state <= ST_RETRY;
            end else begin
              verr_q <= 1'b1;
              state  <= ST_ERR;
            end
`else
            verr_q <= 1'b1;
            state  <= ST_ERR;
`endif
          end else begin
            watch <= watch + 7'd1;
          end
        end
`ifdef APEX_ARB_RETRY_EN
        ST_RETRY: begin
          gnt_q <= cat_onehot(winner_q);
          ibt_q <= ibt_of(winner_q);
          watch <= '0;
          state <= ST_GRANT;
        end
`endif
        ST_ERR: begin
          gnt_q  <= '0;
          ibt_q  <= IBT_NONE;
          verr_q <= 1'b1;
        end
        default: begin
          gnt_q  <= '0;
          ibt_q  <= IBT_NONE;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.ibt  = ibt_q;
  assign bus.busy = busy_q;
  assign bus.verr = verr_q;

endmodule

// File: tb/tb_apex_cat_arbiter.sv
// Directed self-checking bench for apex_cat_arbiter (WATCH_MAX=8, RETRY_MAX=2);
// follows APEX_ARB_RETRY_EN to pick the expected timeout behaviour.
module tb_apex_cat_arbiter;

  logic clk;
  logic rst_n;
  logic iclr;
  int   check_cnt;
  int   pass_cnt;

  apex_cat_arbiter_if bus_if ();

  apex_cat_arbiter #(
    .WATCH_MAX (8),
    .RETRY_MAX (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iclr  (iclr),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iclr = 1'b0;
    bus_if.req = '0;
    bus_if.done = 1'b0;
    #3;
    check_cnt++;
    if ({bus_if.gnt, bus_if.ibt, bus_if.busy, bus_if.verr} !== 11'b0)
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {bus_if.gnt, bus_if.ibt, bus_if.busy, bus_if.verr}, 11'b0);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus_if.req = 6'b000001;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000001 || bus_if.ibt !== 3'b010 || bus_if.busy !== 1'b1)
      $display("[TB] FAIL single_grant: got gnt=%b ibt=%b busy=%b expected 000001/010/1",
               bus_if.gnt, bus_if.ibt, bus_if.busy);
    else pass_cnt++;
    bus_if.req = '0;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000001)
      $display("[TB] FAIL req_drop_holds: got %b expected %b", bus_if.gnt, 6'b000001);
    else pass_cnt++;
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    check_cnt++;
    if (bus_if.gnt !== 6'b0 || bus_if.ibt !== 3'b000 || bus_if.busy !== 1'b0)
      $display("[TB] FAIL single_release: got gnt=%b ibt=%b busy=%b expected 000000/000/0",
               bus_if.gnt, bus_if.ibt, bus_if.busy);
    else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [5:0] exp_gnt;
    logic [2:0] exp_ibt;
    iclr = 1'b1;
    tick();
    iclr = 1'b0;
    bus_if.req = 6'b111111;
    for (int k = 0; k < 7; k++) begin
      exp_gnt = 6'b000001 << (k % 6);
      exp_ibt = 3'((k % 6) + 2);
      tick();
      check_cnt++;
      if (bus_if.gnt !== exp_gnt || bus_if.ibt !== exp_ibt)
        $display("[TB] FAIL rotation_grant%0d: got gnt=%b ibt=%b expected %b/%b",
                 k, bus_if.gnt, bus_if.ibt, exp_gnt, exp_ibt);
      else pass_cnt++;
      bus_if.done = 1'b1;
      tick();
      bus_if.done = 1'b0;
      check_cnt++;
      if (bus_if.gnt !== 6'b0)
        $display("[TB] FAIL rotation_gap%0d: got %b expected %b", k, bus_if.gnt, 6'b0);
      else pass_cnt++;
    end
    bus_if.req = '0;
  endtask

  task automatic test_timeout();
    int hc;
    bus_if.req = 6'b000100;
    tick();
    hc = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.gnt !== 6'b000100) break;
      hc++;
    end
    check_cnt++;
    if (hc !== 8) $display("[TB] FAIL timeout_high1: got %0d cycles expected 8", hc);
    else pass_cnt++;
`ifdef APEX_ARB_RETRY_EN
    check_cnt++;
    if (bus_if.gnt !== 6'b0 || bus_if.verr !== 1'b0 || bus_if.busy !== 1'b1)
      $display("[TB] FAIL retry_gap: got gnt=%b verr=%b busy=%b expected 000000/0/1",
               bus_if.gnt, bus_if.verr, bus_if.busy);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000100 || bus_if.ibt !== 3'b100)
      $display("[TB] FAIL retry_regrant: got gnt=%b ibt=%b expected 000100/100",
               bus_if.gnt, bus_if.ibt);
    else pass_cnt++;
    hc = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.gnt !== 6'b000100) break;
      hc++;
    end
    check_cnt++;
    if (hc !== 8) $display("[TB] FAIL timeout_high2: got %0d cycles expected 8", hc);
    else pass_cnt++;
`endif
    check_cnt++;
    if (bus_if.verr !== 1'b1 || bus_if.gnt !== 6'b0 || bus_if.ibt !== 3'b000)
      $display("[TB] FAIL timeout_err: got verr=%b gnt=%b ibt=%b expected 1/000000/000",
               bus_if.verr, bus_if.gnt, bus_if.ibt);
    else pass_cnt++;
  endtask

  task automatic test_err_hold();
    bus_if.req = 6'b111111;
    bus_if.done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus_if.done = 1'b0;
    check_cnt++;
    if (bus_if.verr !== 1'b1 || bus_if.gnt !== 6'b0 || bus_if.busy !== 1'b1)
      $display("[TB] FAIL err_sticky: got verr=%b gnt=%b busy=%b expected 1/000000/1",
               bus_if.verr, bus_if.gnt, bus_if.busy);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    bus_if.req = '0;
    iclr = 1'b1;
    tick();
    iclr = 1'b0;
    check_cnt++;
    if (bus_if.verr !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.gnt !== 6'b0)
      $display("[TB] FAIL iclr_clear: got verr=%b busy=%b gnt=%b expected 0/0/000000",
               bus_if.verr, bus_if.busy, bus_if.gnt);
    else pass_cnt++;
    bus_if.req = 6'b111111;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000001 || bus_if.ibt !== 3'b010)
      $display("[TB] FAIL iclr_first_cat0: got gnt=%b ibt=%b expected 000001/010",
               bus_if.gnt, bus_if.ibt);
    else pass_cnt++;
    bus_if.req = '0;
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus_if.req = 6'b000010;
    tick();
`ifdef APEX_ARB_RETRY_EN
    for (int i = 0; i < 8; i++) tick();
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000010)
      $display("[TB] FAIL simul_regrant: got %b expected %b", bus_if.gnt, 6'b000010);
    else pass_cnt++;
`endif
    for (int i = 0; i < 7; i++) tick();
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0;
    bus_if.req = '0;
    check_cnt++;
    if (bus_if.gnt !== 6'b0 || bus_if.busy !== 1'b0 || bus_if.verr !== 1'b0)
      $display("[TB] FAIL simul_done_wins: got gnt=%b busy=%b verr=%b expected 000000/0/0",
               bus_if.gnt, bus_if.busy, bus_if.verr);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (bus_if.verr !== 1'b0 || bus_if.busy !== 1'b0)
      $display("[TB] FAIL simul_idle_after: got verr=%b busy=%b expected 0/0",
               bus_if.verr, bus_if.busy);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    bus_if.req = 6'b001000;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b001000 || bus_if.ibt !== 3'b101)
      $display("[TB] FAIL areset_pre_grant: got gnt=%b ibt=%b expected 001000/101",
               bus_if.gnt, bus_if.ibt);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (bus_if.gnt !== 6'b0 || bus_if.ibt !== 3'b000 || bus_if.busy !== 1'b0)
      $display("[TB] FAIL areset_no_clk: got gnt=%b ibt=%b busy=%b expected 000000/000/0",
               bus_if.gnt, bus_if.ibt, bus_if.busy);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    bus_if.req = 6'b001001;
    tick();
    check_cnt++;
    if (bus_if.gnt !== 6'b000001)
      $display("[TB] FAIL areset_ptr5: got %b expected %b", bus_if.gnt, 6'b000001);
    else pass_cnt++;
    bus_if.req = '0;
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt = 0;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_err_hold();
    test_clear();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: run exceeded time budget");
    $fatal(1, "[TB] stopped");
  end

endmodule

// File: doc/apex_cat_arbiter.md
# apex_cat_arbiter

Round-robin arbiter and watchdog sequencer for the six category request lines (cat0..cat5) that feed the ibt-selected pluto/star datapath. It grants one category at a time and drives the matching 3-bit ibt code to the datapath. It times each grant with a watch counter and retries a stuck grant. On exhaustion it raises a sticky verify error. It sits between the category sources and the ibt/pluto capture logic.

## Interface
- WATCH_MAX, 100, cycles a grant may stay open without `done`; range 2..127; 7-bit counter.
- RETRY_MAX, 3, timeouts tolerated per grant before error; range 1..15; 4-bit counter.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iclr  in  1  synchronous clear; overrides all other inputs.
- req  in  6  category requests; bit k = cat k.
- done  in  1  the granted requester has finished.
- gnt  out  6  one-hot grant, registered.
- ibt  out  3  ibt code of the current grant, registered.
- busy  out  1  high when state is not IDLE.
- verr  out  1  sticky timeout error.

## Operation
- States: IDLE, GRANT, RETRY, ERR.
- Reset values: state IDLE, gnt 0, ibt 3'b000, busy 0, verr 0, watch 0, star 0, pointer 5. Pointer 5 makes cat0 the first winner.
- ibt encoding: winner k gives ibt = k+2, so cat0=010 and cat5=111. With no grant, ibt = 000.
- IDLE: if req != 0, pick the first set bit searching from pointer+1 modulo 6. Load gnt/ibt, clear watch and star, then go to GRANT. `done` is ignored in IDLE.
- GRANT: watch increments each cycle. A requester dropping req does not end the grant.
  - done=1: clear gnt/ibt, set pointer = winner, go to IDLE.
  - Timeout when watch == WATCH_MAX-1 and done=0: star increments, gnt/ibt clear.
  - After a timeout, go to RETRY if star+1 < RETRY_MAX. Otherwise go to ERR.
  - If done and timeout occur in the same cycle, done wins and no timeout is counted.
- RETRY: lasts one cycle with gnt=0. Then re-grant the same winner with watch cleared and star kept, and return to GRANT.
- ERR: verr=1, gnt=0, req ignored. Only iclr or rst_n leaves ERR.
- iclr=1 in any state: next state IDLE; verr, watch and star clear; gnt/ibt clear; pointer = 5.

## Timing
- req sampled at edge n (state IDLE) gives gnt/ibt valid after edge n.
- done sampled high at edge m gives gnt=0 after edge m; state IDLE after edge m.
- The earliest next grant comes one edge later, so there is at least one cycle of gnt=0 between grants.
- A grant with no done stays high exactly WATCH_MAX cycles. It is followed by 1 cycle low (RETRY), then re-grant.
- verr rises on the edge that would have started the final retry, and stays high.
- rst_n low: all outputs reach their reset values immediately, without waiting for clk.

## Configuration
- APEX_ARB_RETRY_EN defined: RETRY state and star counter present, as described above.
- APEX_ARB_RETRY_EN undefined: the first timeout goes directly to ERR. RETRY and star are removed, and RETRY_MAX is ignored.

## Structure
- Package apex_arb_pkg holds:
  - the state enum;
  - NUM_CAT = 6;
  - the constants IBT_NONE = 3'b000 and IBT_BASE = 3'd2;
  - a function mapping winner index to ibt code.
- Sub-module apex_rr_pick: combinational 6-way round-robin picker. Inputs are req and pointer; outputs are a winner index and a valid flag.
- The FSM, watch/star counters and output registers live in apex_cat_arbiter.

## Test plan
- Single request: after reset, req=6'b000001 gives gnt=000001 and ibt=010 one cycle later. done=1 for one cycle gives gnt=0 and busy=0 on the following cycle.
- Rotation: req=6'b111111 held, done pulsed during each grant. Grants run cat0..cat5 then cat0 again, with ibt 010..111, and each grant is separated by one gnt=0 cycle.
- Timeout (WATCH_MAX=8, RETRY_MAX=2, no done):
  - Macro defined: gnt high 8 cycles, low 1, high 8, then verr=1 with gnt=0.
  - Macro undefined: verr=1 after the first 8 cycles.
- Simultaneous events: done=1 on the cycle where watch==WATCH_MAX-1. The grant releases normally, verr stays 0, and star is unchanged.
- Clear and reset: iclr in ERR clears verr and returns to IDLE, and the next grant goes to cat0. rst_n dropped mid-grant forces gnt=0 and ibt=000 without a clk edge.
